// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants, state encoding and colour word width.
package ws2812_pkg;

   // Line timing in ns, shared with the LED driver
   localparam int unsigned T0H_NS      = 400;
   localparam int unsigned T1H_NS      = 800;
   localparam int unsigned PERIOD_NS   = 1250;
   localparam int unsigned RESET_NS    = 50000;

   // Receiver decision points derived from the line timing
   localparam int unsigned THRESH_NS   = (T0H_NS + T1H_NS) / 2;
   localparam int unsigned HIGH_MAX_NS = 2000;
   localparam int unsigned LOW_MAX_NS  = 4 * PERIOD_NS;

   localparam int unsigned RGB_W       = 24;
   localparam int unsigned IDX_W       = 8;

   localparam int unsigned STATE_W     = 2;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_SYNC = 2'd0;
   localparam state_t S_IDLE = 2'd1;
   localparam state_t S_HIGH = 2'd2;
   localparam state_t S_LOW  = 2'd3;

   // Convert a duration in ns to whole clock cycles at clk_mhz
   function automatic int unsigned ns_to_cycles(input int unsigned ns, input int unsigned clk_mhz);
      return (ns * clk_mhz) / 1000;
   endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded-word output bundle of the WS2812 receiver.
interface ws2812_rx_if;
   import ws2812_pkg::*;

   logic [RGB_W-1:0] rgb_data;
   logic             rgb_valid;
   logic [IDX_W-1:0] word_index;
   logic             frame_done;
   logic             error;

   modport master (output rgb_data, rgb_valid, word_index, frame_done, error);
   modport slave  (input  rgb_data, rgb_valid, word_index, frame_done, error);

endinterface

// File: rtl/ws2812_pulse_meter.sv
// Synchronizes the WS2812 line, detects edges and measures the current level's width.
module ws2812_pulse_meter #(
   parameter int unsigned T_RESET_MIN = 500,
   parameter int unsigned COUNT_BITS  = $clog2(T_RESET_MIN + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  din,
   output logic                  rise,
   output logic                  fall,
   output logic                  level,
   output logic [COUNT_BITS-1:0] count
);

   localparam logic [COUNT_BITS-1:0] CNT_MAX = COUNT_BITS'(T_RESET_MIN);

   logic                  meta_q, meta_d;
   logic                  sync_q, sync_d;
   logic                  prev_q, prev_d;
   logic [COUNT_BITS-1:0] count_q, count_d;

   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;
   assign level = sync_q;
   assign count = count_q;

   // Synchronizer chain and saturating width counter (restarts at 1 on each edge)
   always_comb begin
      meta_d  = din;
      sync_d  = meta_q;
      prev_d  = sync_q;
      count_d = count_q;
      if (rise || fall) begin
         count_d = COUNT_BITS'(1);
      end else if (count_q != CNT_MAX) begin
         count_d = count_q + COUNT_BITS'(1);
      end
   end

   // Register update
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         count_q <= '0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: decodes MSB-first 24-bit words, flags frame gaps and timing errors.
// Optional daisy-chain forwarding on dout when WS2812_RX_FWD_EN is defined.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int unsigned CLK_MHZ = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        din,
   ws2812_rx_if.master rx,
   output logic        dout
);

   localparam int unsigned T_THRESH    = ns_to_cycles(THRESH_NS, CLK_MHZ);
   localparam int unsigned T_HIGH_MAX  = ns_to_cycles(HIGH_MAX_NS, CLK_MHZ);
   localparam int unsigned T_LOW_MAX   = ns_to_cycles(LOW_MAX_NS, CLK_MHZ);
   localparam int unsigned T_RESET_MIN = ns_to_cycles(RESET_NS, CLK_MHZ);
   localparam int unsigned COUNT_BITS  = $clog2(T_RESET_MIN + 1);
   localparam int unsigned BIT_CNT_W   = $clog2(RGB_W);

   localparam logic [COUNT_BITS-1:0] THRESH_C   = COUNT_BITS'(T_THRESH);
   localparam logic [COUNT_BITS-1:0] HIGH_MAX_C = COUNT_BITS'(T_HIGH_MAX);
   localparam logic [COUNT_BITS-1:0] LOW_MAX_C  = COUNT_BITS'(T_LOW_MAX);
   localparam logic [COUNT_BITS-1:0] RESET_C    = COUNT_BITS'(T_RESET_MIN);
   localparam logic [BIT_CNT_W-1:0]  LAST_BIT   = BIT_CNT_W'(RGB_W - 1);
   localparam logic [IDX_W-1:0]      IDX_MAX    = '1;

   logic                  rise, fall, level;
   logic [COUNT_BITS-1:0] count;

   state_t                state_q, state_d;
   // Holds the first 23 bits of a word; the 24th is merged straight into rgb_data
   logic [RGB_W-2:0]      shift_q, shift_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]      words_q, words_d;
   logic [RGB_W-1:0]      rgb_data_q, rgb_data_d;
   logic [IDX_W-1:0]      word_index_q, word_index_d;
   logic                  rgb_valid_q, rgb_valid_d;
   logic                  frame_done_q, frame_done_d;
   logic                  error_q, error_d;
   logic                  frame_start;
   logic                  bit_val;

   ws2812_pulse_meter #(
      .T_RESET_MIN (T_RESET_MIN),
      .COUNT_BITS  (COUNT_BITS)
   ) u_meter (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .rise  (rise),
      .fall  (fall),
      .level (level),
      .count (count)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_SYNC;
      else       state_q <= state_d;
   end

   // Next-state logic; a rise that closes a full reset gap starts the new frame at once
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_SYNC: begin
            if (count >= RESET_C) begin
               if (rise)        state_d = S_HIGH;
               else if (!level) state_d = S_IDLE;
            end
         end
         S_IDLE: if (rise) state_d = S_HIGH;
         S_HIGH: begin
            if (count >= HIGH_MAX_C) state_d = S_SYNC;
            else if (fall)           state_d = S_LOW;
         end
         S_LOW: begin
            if (count >= RESET_C) state_d = rise ? S_HIGH : S_IDLE;
            else if (rise)        state_d = (count <= LOW_MAX_C) ? S_HIGH : S_SYNC;
         end
         default: state_d = S_SYNC;
      endcase
   end

   // Datapath and output pulses for the current state
   always_comb begin
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      words_d      = words_q;
      rgb_data_d   = rgb_data_q;
      word_index_d = word_index_q;
      rgb_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      error_d      = 1'b0;
      frame_start  = 1'b0;
      bit_val      = (count >= THRESH_C);
      unique case (state_q)
         S_SYNC: frame_start = (count >= RESET_C) && rise;
         S_IDLE: frame_start = rise;
         S_HIGH: begin
            if (count >= HIGH_MAX_C) begin
               error_d = 1'b1;
            end else if (fall) begin
               shift_d = {shift_q[RGB_W-3:0], bit_val};
               if (bit_cnt_q == LAST_BIT) begin
                  rgb_data_d   = {shift_q, bit_val};
                  rgb_valid_d  = 1'b1;
                  word_index_d = words_q;
                  bit_cnt_d    = '0;
                  if (words_q != IDX_MAX) words_d = words_q + IDX_W'(1);
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         S_LOW: begin
            if (count >= RESET_C) begin
               frame_done_d = 1'b1;
               error_d      = (bit_cnt_q != '0);
               bit_cnt_d    = '0;
               frame_start  = rise;
            end else if (rise && (count > LOW_MAX_C)) begin
               error_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (frame_start) begin
         bit_cnt_d    = '0;
         words_d      = '0;
         word_index_d = '0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         words_q      <= '0;
         rgb_data_q   <= '0;
         word_index_q <= '0;
         rgb_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         words_q      <= words_d;
         rgb_data_q   <= rgb_data_d;
         word_index_q <= word_index_d;
         rgb_valid_q  <= rgb_valid_d;
         frame_done_q <= frame_done_d;
         error_q      <= error_d;
      end
   end

   assign rx.rgb_data   = rgb_data_q;
   assign rx.rgb_valid  = rgb_valid_q;
   assign rx.word_index = word_index_q;
   assign rx.frame_done = frame_done_q;
   assign rx.error      = error_q;

`ifdef WS2812_RX_FWD_EN
   logic fwd_q, fwd_d;
   logic dout_q, dout_d;

   // Forward the line once the first word is consumed, until the frame ends or breaks
   always_comb begin
      fwd_d = fwd_q;
      if (frame_start)             fwd_d = 1'b0;
      if (rgb_valid_d)             fwd_d = 1'b1;
      if (frame_done_d || error_d) fwd_d = 1'b0;
      dout_d = fwd_q & level;
   end

   // Forwarding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_q  <= 1'b0;
         dout_q <= 1'b0;
      end else begin
         fwd_q  <= fwd_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;
`else
   assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed self-checking bench for ws2812_rx (plus a downstream receiver on dout).
module tb_ws2812_rx;

   logic clk = 1'b0;
   logic reset;
   logic din;
   logic dout;
   logic ds_dout;

   ws2812_rx_if rx_if ();
   ws2812_rx_if ds_if ();

   ws2812_rx u_dut (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .rx    (rx_if),
      .dout  (dout)
   );

   ws2812_rx u_ds (
      .clk   (clk),
      .reset (reset),
      .din   (dout),
      .rx    (ds_if),
      .dout  (ds_dout)
   );

   always #50 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [23:0] got_data[$];
   logic [7:0]  got_idx[$];
   logic [23:0] ds_data[$];
   logic [7:0]  ds_idx[$];
   int n_done, n_err, n_both, n_dout_hi, n_fwd_bad;
   logic fwd_win = 1'b0;
   logic [2:0] din_hist = 3'b000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] qd(input int i);
      return (i < got_data.size()) ? 32'(got_data[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] qi(input int i);
      return (i < got_idx.size()) ? 32'(got_idx[i]) : 32'hFFFF_FFFF;
   endfunction

   always @(posedge clk) din_hist <= {din_hist[1:0], din};

   // Event recorder, sampled mid-cycle
   always @(negedge clk) begin
      if (rx_if.rgb_valid) begin
         got_data.push_back(rx_if.rgb_data);
         got_idx.push_back(rx_if.word_index);
      end
      if (ds_if.rgb_valid) begin
         ds_data.push_back(ds_if.rgb_data);
         ds_idx.push_back(ds_if.word_index);
      end
      if (rx_if.frame_done) n_done++;
      if (rx_if.error) n_err++;
      if (rx_if.frame_done && rx_if.error) n_both++;
      if (dout) n_dout_hi++;
      if (fwd_win && (dout !== din_hist[2])) n_fwd_bad++;
   end

   task automatic clear_mon();
      got_data.delete();
      got_idx.delete();
      ds_data.delete();
      ds_idx.delete();
      n_done = 0; n_err = 0; n_both = 0; n_dout_hi = 0; n_fwd_bad = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic low(input int n);
      din = 1'b0;
      tick(n);
   endtask

   task automatic send_bit(input logic b);
      din = 1'b1;
      tick(b ? 9 : 4);
      din = 1'b0;
      tick(b ? 4 : 9);
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[23-i]);
   endtask

   task automatic send_word(input logic [23:0] w);
      send_bits(w, 24);
   endtask

   task automatic send_word_t(input logic [23:0] w, input int hi1, input int hi0, input int lo);
      for (int i = 0; i < 24; i++) begin
         din = 1'b1;
         tick(w[23-i] ? hi1 : hi0);
         din = 1'b0;
         tick(lo);
      end
   endtask

   task automatic check_counts(input string tag, input int words, input int done, input int err);
      check({tag, "_words"}, 32'(got_data.size()), 32'(words));
      check({tag, "_done"}, 32'(n_done), 32'(done));
      check({tag, "_err"}, 32'(n_err), 32'(err));
   endtask

   initial begin
      reset = 1'b1;
      din   = 1'b0;
      clear_mon();
      tick(5);
      check("rst_data", 32'(rx_if.rgb_data), 32'h0);
      check("rst_valid", 32'(rx_if.rgb_valid), 32'h0);
      check("rst_index", 32'(rx_if.word_index), 32'h0);
      check("rst_done", 32'(rx_if.frame_done), 32'h0);
      check("rst_error", 32'(rx_if.error), 32'h0);
      check("rst_dout", 32'(dout), 32'h0);
      reset = 1'b0;
      low(600);
      check("sync_no_done", 32'(n_done), 32'h0);

      // Single word
      clear_mon();
      send_word(24'hA5C31E);
      low(600);
      check_counts("t1", 1, 1, 0);
      check("t1_data", qd(0), 32'hA5C31E);
      check("t1_idx", qi(0), 32'h0);

      // Three words in one frame
      clear_mon();
      send_word(24'h000001);
      send_word(24'hFF0000);
      send_word(24'h00FF00);
      low(600);
      check_counts("t2", 3, 1, 0);
      check("t2_data0", qd(0), 32'h000001);
      check("t2_data1", qd(1), 32'hFF0000);
      check("t2_data2", qd(2), 32'h00FF00);
      check("t2_idx0", qi(0), 32'd0);
      check("t2_idx1", qi(1), 32'd1);
      check("t2_idx2", qi(2), 32'd2);

      // Over-long high pulse, then recovery after a reset gap
      clear_mon();
      for (int i = 0; i < 24; i++) begin
         if (i == 10) begin
            din = 1'b1; tick(25); din = 1'b0; tick(4);
         end else begin
            send_bits(24'h123456 << i, 1);
         end
      end
      low(500);
      send_word(24'h00000F);
      low(600);
      check_counts("t3", 1, 1, 1);
      check("t3_data", qd(0), 32'h00000F);
      check("t3_idx", qi(0), 32'h0);

      // Intra-frame gap too long
      clear_mon();
      send_bits(24'hABC000, 12);
      low(100);
      send_bits(24'h555000, 12);
      low(600);
      check_counts("t4a", 0, 0, 1);

      // Partial word ended by a reset gap
      clear_mon();
      send_bits(24'hABC000, 12);
      low(600);
      check_counts("t4b", 0, 1, 1);
      check("t4b_both", 32'(n_both), 32'd1);
      check("t4b_data_kept", 32'(rx_if.rgb_data), 32'h00000F);

      // Reset mid-frame, then a frame without a preceding gap
      clear_mon();
      send_bits(24'hF0F0F0, 10);
      reset = 1'b1;
      tick(1);
      check("t5_rst_data", 32'(rx_if.rgb_data), 32'h0);
      check("t5_rst_error", 32'(rx_if.error), 32'h0);
      tick(2);
      reset = 1'b0;
      send_word(24'h0F0F0F);
      low(600);
      check_counts("t5a", 0, 0, 0);
      clear_mon();
      send_word(24'h0F0F0F);
      low(600);
      check_counts("t5b", 1, 1, 0);
      check("t5b_data", qd(0), 32'h0F0F0F);

      // Gap of exactly T_RESET_MIN ends the frame and starts the next
      clear_mon();
      send_word(24'h000001);
      low(496);
      send_word(24'h5A5A5A);
      low(600);
      check_counts("t6a", 2, 2, 0);
      check("t6a_data1", qd(1), 32'h5A5A5A);
      check("t6a_idx1", qi(1), 32'h0);

      // Gap one short of T_RESET_MIN is a violation
      clear_mon();
      send_word(24'h000001);
      low(495);
      send_word(24'h5A5A5A);
      low(600);
      check_counts("t6b", 1, 0, 1);

      // Intra-frame low of exactly T_LOW_MAX is legal, one more is not
      clear_mon();
      send_word_t(24'h3C5A69, 9, 4, 50);
      low(600);
      send_word_t(24'h3C5A69, 9, 4, 51);
      low(600);
      check_counts("t7", 1, 1, 1);
      check("t7_data", qd(0), 32'h3C5A69);

      // High-time thresholds: 5 -> 0, 6 -> 1, 19 -> 1, 20 -> violation
      clear_mon();
      send_word_t(24'hA5C31E, 6, 5, 4);
      low(600);
      send_word_t(24'h5A3CC3, 19, 1, 1);
      low(600);
      din = 1'b1; tick(20); din = 1'b0;
      low(600);
      check_counts("t8", 2, 2, 1);
      check("t8_data0", qd(0), 32'hA5C31E);
      check("t8_data1", qd(1), 32'h5A3CC3);

      // word_index saturation
      clear_mon();
      for (int k = 0; k < 257; k++) send_word_t(24'h0, 1, 1, 1);
      low(600);
      check_counts("t9", 257, 1, 0);
      check("t9_idx254", qi(254), 32'd254);
      check("t9_idx255", qi(255), 32'd255);
      check("t9_idx256", qi(256), 32'd255);
      check("t9_data", qd(256), 32'h0);

`ifdef WS2812_RX_FWD_EN
      // Forwarding: first word swallowed, rest delayed by 3 cycles
      clear_mon();
      send_word(24'h111111);
      check("fwd_quiet_word0", 32'(n_dout_hi), 32'd0);
      fwd_win = 1'b1;
      send_word(24'h222222);
      tick(20);
      fwd_win = 1'b0;
      low(600);
      check("fwd_hi_cycles", 32'(n_dout_hi), 32'd126);
      check("fwd_delay", 32'(n_fwd_bad), 32'd0);
      check("fwd_up_words", 32'(got_data.size()), 32'd2);
      check("fwd_ds_words", 32'(ds_data.size()), 32'd1);
      check("fwd_ds_data", (ds_data.size() > 0) ? 32'(ds_data[0]) : 32'hFFFF_FFFF, 32'h222222);
      check("fwd_ds_idx", (ds_idx.size() > 0) ? 32'(ds_idx[0]) : 32'hFFFF_FFFF, 32'h0);
`else
      check("dout_tied", 32'(n_dout_hi), 32'd0);
      check("ds_silent", 32'(ds_data.size()), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
